// File: rtl/downstream_cancel_processor.sv
// Per-client cancelled-quantity table with a 3-cycle read-modify-write update path
// and a handshake-free clear. Define DOWNSTREAM_SATURATE_EN for saturating sums plus sat_flag.
module downstream_cancel_processor #(
    parameter int AMT_W    = 16,
    parameter int CLIENT_W = 5
) (
    input  logic                clk,
    input  logic                HRESETn,
    input  logic                cxl_valid,
    output logic                cxl_ready,
    input  logic [CLIENT_W-1:0] cxl_client_id,
    input  logic [AMT_W-1:0]    cxl_amount,
    input  logic                clr_valid,
    input  logic [CLIENT_W-1:0] clr_client_id,
    input  logic [CLIENT_W-1:0] rd_client_id,
    output logic [AMT_W-1:0]    cancelled_orders,
`ifdef DOWNSTREAM_SATURATE_EN
    output logic                sat_flag,
`endif
    output logic                upd_done,
    output logic                busy
);

    localparam int DEPTH = 1 << CLIENT_W;

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t                          state, state_nxt;
    logic                            armed;
    logic                            accept, do_write;
    logic [CLIENT_W-1:0]             cur_id;
    logic [AMT_W-1:0]                cur_amt, cur_base, base_eff;
    logic [AMT_W:0]                  sum_full;
    logic [AMT_W-1:0]                wr_data;
    logic                            clr_hit;
    logic [DEPTH-1:0][AMT_W-1:0]     tbl;

    // armed keeps cxl_ready low until the first edge after reset release
    assign cxl_ready        = armed && (state == IDLE);
    assign busy             = (state != IDLE);
    assign cancelled_orders = tbl[rd_client_id];
    assign clr_hit          = clr_valid && (clr_client_id == cur_id);

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        do_write  = 1'b0;
        unique case (state)
            IDLE:  if (cxl_valid && cxl_ready) begin
                       accept    = 1'b1;
                       state_nxt = READ;
                   end
            READ:  state_nxt = WRITE;
            WRITE: begin
                       do_write  = 1'b1;
                       state_nxt = IDLE;
                   end
            default: state_nxt = IDLE;
        endcase
    end

    // A clear landing on the write edge wins over the latched base: result is amount only
    assign base_eff = clr_hit ? '0 : cur_base;
    assign sum_full = {1'b0, base_eff} + {1'b0, cur_amt};

`ifdef DOWNSTREAM_SATURATE_EN
    assign wr_data = sum_full[AMT_W] ? {AMT_W{1'b1}} : sum_full[AMT_W-1:0];
`else
    logic wrap_carry_unused;
    assign wrap_carry_unused = sum_full[AMT_W];
    assign wr_data           = sum_full[AMT_W-1:0];
`endif

    always_ff @(posedge clk or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= IDLE;
            armed    <= 1'b0;
            cur_id   <= '0;
            cur_amt  <= '0;
            cur_base <= '0;
            upd_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            armed    <= 1'b1;
            upd_done <= do_write;
            if (accept) begin
                cur_id  <= cxl_client_id;
                cur_amt <= cxl_amount;
            end
            if (state == READ)
                cur_base <= clr_hit ? '0 : tbl[cur_id];
        end
    end

`ifdef DOWNSTREAM_SATURATE_EN
    always_ff @(posedge clk or negedge HRESETn) begin
        if (!HRESETn)
            sat_flag <= 1'b0;
        else if (do_write && sum_full[AMT_W])
            sat_flag <= 1'b1;
    end
`endif

    // Write to the in-flight client takes priority; a clear to any other client lands too
    always_ff @(posedge clk or negedge HRESETn) begin
        if (!HRESETn) begin
            tbl <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (do_write && cur_id == CLIENT_W'(i))
                    tbl[i] <= wr_data;
                else if (clr_valid && clr_client_id == CLIENT_W'(i))
                    tbl[i] <= '0;
            end
        end
    end

endmodule

// File: doc/downstream_cancel_processor.md
DOWNSTREAM_CANCEL_PROCESSOR -- requirements
Module: downstream_cancel_processor

Interface
REQ-001 SHALL have parameter: AMT_W, default 16, width of order/cancel amounts and table entries.
REQ-002 SHALL have parameter: CLIENT_W, default 5, client id width; table depth 2**CLIENT_W (32).
REQ-003 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port: HRESETn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: cxl_valid  input  1  cancel report from exchange side valid.
REQ-006 SHALL have port: cxl_ready  output  1  block can accept a cancel report.
REQ-007 SHALL have port: cxl_client_id  input  CLIENT_W  client of cancel report.
REQ-008 SHALL have port: cxl_amount  input  AMT_W  cancelled quantity.
REQ-009 SHALL have port: clr_valid  input  1  upstream consumed client's cancelled total; zero it.
REQ-010 SHALL have port: clr_client_id  input  CLIENT_W  client to clear.
REQ-011 SHALL have port: rd_client_id  input  CLIENT_W  upstream query client.
REQ-012 SHALL have port: cancelled_orders  output  AMT_W  cancelled total of rd_client_id.
REQ-013 SHALL have port: upd_done  output  1  one-cycle pulse, table entry updated.
REQ-014 SHALL have port: busy  output  1  FSM not in IDLE.

Function
REQ-015 SHALL hold a 2**CLIENT_W x AMT_W cancelled-total table, one entry per client.
REQ-016 SHALL drive cancelled_orders combinationally as table[rd_client_id]; writes visible the cycle after the write edge.
REQ-017 SHALL implement FSM IDLE -> READ -> WRITE -> IDLE; cxl_ready = 1 only in IDLE.
REQ-018 SHALL accept a report when cxl_valid && cxl_ready at edge N, latching client and amount; READ at N+1 latches table[client]; WRITE at N+2 writes latched entry + amount.
REQ-019 SHALL pulse upd_done high for exactly the cycle following the WRITE edge; busy high in READ and WRITE.
REQ-020 SHALL sustain one accepted report per 3 cycles; cxl_valid held while cxl_ready low SHALL NOT be lost.
REQ-021 SHALL zero table[clr_client_id] on any edge where clr_valid is high, in every FSM state, no handshake.
REQ-022 SHALL, on clear in READ cycle for in-flight client, latch 0 instead of table value.
REQ-023 SHALL, on clear in WRITE cycle for in-flight client, write cxl amount only (clear applied before add).
REQ-024 SHALL treat clear and write to different clients in the same cycle as independent; both take effect.
REQ-025 SHALL perform addition at AMT_W+1 bits; overflow handling per REQ-030/031.

Reset
REQ-026 SHALL, on HRESETn low, immediately force FSM IDLE, all table entries 0, cxl_ready 0, upd_done 0, busy 0.
REQ-027 SHALL drop any in-flight report on reset mid-operation; no partial write.
REQ-028 SHALL raise cxl_ready on the first rising edge after HRESETn deasserts.

Configuration
REQ-029 SHALL use macro DOWNSTREAM_SATURATE_EN.
REQ-030 SHALL, with DOWNSTREAM_SATURATE_EN defined, saturate sums to 2**AMT_W-1 and add output sat_flag (1 bit, sticky, cleared only by reset) set on any saturation.
REQ-031 SHALL, without DOWNSTREAM_SATURATE_EN, wrap sums modulo 2**AMT_W and omit sat_flag.

Verification
REQ-032 SHALL cover: reset, report client 3 amount 100 accepted edge N -> table[3]=100 read on cancelled_orders from N+3, upd_done pulse at N+3.
REQ-033 SHALL cover: two reports client 7 amounts 40 then 60 with cxl_valid held -> second waits for cxl_ready, table[7]=100, two upd_done pulses.
REQ-034 SHALL cover: table[5]=50, report client 5 amount 20 with clr_valid client 5 in WRITE cycle -> table[5]=20; clear in READ cycle -> also 20.
REQ-035 SHALL cover: table[9]=0xFFF0, report amount 0x20 -> 0xFFFF and sat_flag=1 with macro; 0x0010, no sat_flag without.
REQ-036 SHALL cover: HRESETn low during READ of report client 2 amount 30 -> table[2]=0, no upd_done, cxl_ready 1 after release.
